// File: rtl/fpmul_pkg.sv
// Shared state type and field helpers for the sequential small-float multiplier.
// Build option FPMUL_RNE_EN selects round-to-nearest-even; without it results truncate.
package fpmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int unsigned fpmul_bias(input int unsigned ew);
        return (32'd1 << (ew - 32'd1)) - 32'd1;
    endfunction

    // Product bits the rounding stage needs: all of them for RNE, only the kept ones otherwise.
    function automatic int unsigned fpmul_keep_w(input int unsigned mw);
`ifdef FPMUL_RNE_EN
        return 2 * mw + 2;
`else
        return mw + 2;
`endif
    endfunction

    function automatic logic [31:0] fpmul_sign(input logic [31:0] op, input int unsigned ew,
                                               input int unsigned mw);
        return (op >> (ew + mw)) & 32'd1;
    endfunction

    function automatic logic [31:0] fpmul_exp(input logic [31:0] op, input int unsigned ew,
                                              input int unsigned mw);
        return (op >> mw) & ((32'd1 << ew) - 32'd1);
    endfunction

    function automatic logic [31:0] fpmul_frac(input logic [31:0] op, input int unsigned mw);
        return op & ((32'd1 << mw) - 32'd1);
    endfunction

endpackage

// File: rtl/fpmul_round.sv
// Normalise, round and range-check a significand product with its biased exponent.
// Build option FPMUL_RNE_EN adds round-to-nearest-even; otherwise the fraction is truncated.
module fpmul_round
    import fpmul_pkg::*;
#(
    parameter int unsigned EW = 3,
    parameter int unsigned MW = 4
) (
    input  logic [fpmul_keep_w(MW)-1:0] i_prod,
    input  logic signed [EW+1:0]        i_exp,
    input  logic                        i_sign,
    output logic [EW+MW:0]              o_res_c,
    output logic                        o_ovf_c,
    output logic                        o_unf_c
);

    localparam int unsigned KW = fpmul_keep_w(MW);
    localparam int unsigned RW = EW + 3;
    localparam logic signed [RW-1:0] EMAX = RW'((1 << EW) - 1);

    logic                 w_msb;
    logic [MW-1:0]        w_frac;
    logic [MW-1:0]        w_frac_r;
    logic                 w_carry;
    logic signed [RW-1:0] w_exp_n;
    logic signed [RW-1:0] w_exp_f;

    // Product lies in [1,4): at most one right shift brings it back to 1.x
    assign w_msb   = i_prod[KW-1];
    assign w_frac  = w_msb ? i_prod[KW-2 -: MW] : i_prod[KW-3 -: MW];
    assign w_exp_n = RW'(i_exp) + (w_msb ? RW'(1) : RW'(0));

`ifdef FPMUL_RNE_EN
    logic          w_guard;
    logic          w_sticky;
    logic          w_inc;
    logic [MW:0]   w_sum;

    assign w_guard  = w_msb ? i_prod[KW-2-MW] : i_prod[KW-3-MW];
    assign w_sticky = w_msb ? (|i_prod[KW-3-MW:0]) : (|i_prod[KW-4-MW:0]);
    assign w_inc    = w_guard & (w_sticky | w_frac[0]);
    assign w_sum    = {1'b0, w_frac} + (MW+1)'(w_inc);
    assign w_frac_r = w_sum[MW-1:0];
    assign w_carry  = w_sum[MW];
`else
    assign w_frac_r = w_frac;
    assign w_carry  = 1'b0;
`endif

    // A rounding carry wraps the fraction to zero and bumps the exponent
    assign w_exp_f = w_exp_n + (w_carry ? RW'(1) : RW'(0));

    always_comb begin
        o_res_c = {i_sign, w_exp_f[EW-1:0], w_frac_r};
        o_ovf_c = 1'b0;
        o_unf_c = 1'b0;
        if (w_exp_f > EMAX) begin
            o_res_c = {i_sign, {(EW+MW){1'b1}}};
            o_ovf_c = 1'b1;
        end else if (w_exp_f <= RW'(0)) begin
            o_res_c = {i_sign, (EW+MW)'(0)};
            o_unf_c = 1'b1;
        end
    end

endmodule

// File: rtl/fpmul_seq.sv
// Sequential shift-add multiplier for {sign, EW exp, MW frac} floats with valid/ready handshakes.
// Build option FPMUL_RNE_EN (handled in fpmul_round) enables round-to-nearest-even.
module fpmul_seq
    import fpmul_pkg::*;
#(
    parameter int unsigned EW   = 3,
    parameter int unsigned MW   = 4,
    parameter int unsigned BIAS = fpmul_bias(EW)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+MW:0] op_a,
    input  logic [EW+MW:0] op_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] res,
    output logic           ovf,
    output logic           unf
);

    localparam int unsigned OW = EW + MW + 1;
    localparam int unsigned SW = MW + 1;
    localparam int unsigned PW = 2 * MW + 2;
    localparam int unsigned XW = EW + 2;
    localparam int unsigned KW = fpmul_keep_w(MW);
    localparam int unsigned CW = $clog2(SW + 1);

    state_e               r_state;
    state_e               w_next;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [OW-1:0]        r_res;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_sign;
    logic signed [XW-1:0] r_exp;
    logic [PW-1:0]        r_acc;
    logic [PW-1:0]        r_mcand;
    logic [SW-1:0]        r_mplier;
    logic [CW-1:0]        r_cnt;

    logic                 w_sa;
    logic                 w_sb;
    logic [EW-1:0]        w_ea;
    logic [EW-1:0]        w_eb;
    logic [MW-1:0]        w_fa;
    logic [MW-1:0]        w_fb;
    logic                 w_accept;
    logic                 w_zero;
    logic                 w_mul_done;
    logic [OW-1:0]        w_rnd_res;
    logic                 w_rnd_ovf;
    logic                 w_rnd_unf;

    assign w_sa = 1'(fpmul_sign(32'(op_a), EW, MW));
    assign w_sb = 1'(fpmul_sign(32'(op_b), EW, MW));
    assign w_ea = EW'(fpmul_exp(32'(op_a), EW, MW));
    assign w_eb = EW'(fpmul_exp(32'(op_b), EW, MW));
    assign w_fa = MW'(fpmul_frac(32'(op_a), MW));
    assign w_fb = MW'(fpmul_frac(32'(op_b), MW));

    assign w_accept   = in_valid && r_in_ready;
    assign w_zero     = (w_ea == '0) || (w_eb == '0);
    assign w_mul_done = (r_cnt == CW'(SW - 1));

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

    fpmul_round #(
        .EW (EW),
        .MW (MW)
    ) u_round (
        .i_prod  (r_acc[PW-1 -: KW]),
        .i_exp   (r_exp),
        .i_sign  (r_sign),
        .o_res_c (w_rnd_res),
        .o_ovf_c (w_rnd_ovf),
        .o_unf_c (w_rnd_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_zero ? DONE : MUL;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_next = NORM;
                end
            end
            NORM: w_next = DONE;
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, one multiplier bit per MUL cycle, result capture and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else begin
            r_in_ready <= (w_next == IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign   <= w_sa ^ w_sb;
                        r_exp    <= XW'(w_ea) + XW'(w_eb) - XW'(BIAS);
                        r_acc    <= '0;
                        r_mcand  <= PW'({1'b1, w_fa});
                        r_mplier <= {1'b1, w_fb};
                        r_cnt    <= '0;
                        if (w_zero) begin
                            r_res <= {w_sa ^ w_sb, (OW-1)'(0)};
                            r_ovf <= 1'b0;
                            r_unf <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                NORM: begin
                    r_res <= w_rnd_res;
                    r_ovf <= w_rnd_ovf;
                    r_unf <= w_rnd_unf;
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_seq.sv
// Scoreboard bench for fpmul_seq at EW=3, MW=4, BIAS=3: directed vectors, backpressure, reset, random ops.
module tb_fpmul_seq;

`ifdef FPMUL_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct {
        logic [7:0] res;
        logic       ovf;
        logic       unf;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] res;
    logic       ovf;
    logic       unf;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    fpmul_seq #(.EW(3), .MW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t r;
        logic sgn;
        int   ea, eb, p, e, keep, rem, half;
        sgn   = a[7] ^ b[7];
        ea    = int'(a[6:4]);
        eb    = int'(b[6:4]);
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (ea == 0 || eb == 0) begin
            r.res = {sgn, 7'd0};
            r.lat = 1;
            return r;
        end
        r.lat = 7;
        p = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
        e = ea + eb - 3;
        if (p >= 512) begin
            keep = p >> 5; rem = p & 31; half = 16; e = e + 1;
        end else begin
            keep = p >> 4; rem = p & 15; half = 8;
        end
        if (RNE && (rem > half || (rem == half && (keep % 2) == 1))) keep = keep + 1;
        if (keep == 32) begin
            keep = 16; e = e + 1;
        end
        if (e > 7) begin
            r.res = {sgn, 7'h7F}; r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.res = {sgn, 7'h00}; r.unf = 1'b1;
        end else begin
            r.res = {sgn, 3'(e), 4'(keep)};
        end
        return r;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string name, input int hold);
        exp_t e;
        int   lat;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, lat);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s_sb: output with empty scoreboard, res=%h", name, res);
            return;
        end
        e = sb_q.pop_front();
        if (res !== e.res) begin
            bad++;
            $display("FAIL %s_res: got %h required %h", name, res, e.res);
        end
        total++;
        if ({ovf, unf} !== {e.ovf, e.unf}) begin
            bad++;
            $display("FAIL %s_flags: got ovf=%b unf=%b required ovf=%b unf=%b", name, ovf, unf, e.ovf, e.unf);
        end
        total++;
        if (lat != e.lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op_a     = 8'h70;
            op_b     = 8'h70;
            @(posedge clk);
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, res} !== {1'b1, 1'b0, e.res}) begin
                bad++;
                $display("FAIL %s_stall%0d: out_valid=%b in_ready=%b res=%h required 1 0 %h",
                         name, i, out_valid, in_ready, res, e.res);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({in_ready, out_valid, res, ovf, unf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b res=%h ovf=%b unf=%b required 1 0 00 0 0",
                     in_ready, out_valid, res, ovf, unf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        send(8'h38, 8'h38, '{8'h42, 1'b0, 1'b0, 7});
        collect("mul_1p5_1p5", 0);
        send(8'hC0, 8'h38, '{8'hC8, 1'b0, 1'b0, 7});
        collect("mul_neg2_1p5", 0);
        send(8'h00, 8'h38, '{8'h00, 1'b0, 1'b0, 1});
        collect("zero_a", 0);
        send(8'hB5, 8'h80, '{8'h00, 1'b0, 1'b0, 1});
        collect("zero_b_signed", 0);
        send(8'h70, 8'h70, '{8'h7F, 1'b1, 1'b0, 7});
        collect("overflow", 0);
        send(8'h90, 8'h10, '{8'h80, 1'b0, 1'b1, 7});
        collect("underflow", 0);
        send(8'h33, 8'h33, '{RNE ? 8'h37 : 8'h36, 1'b0, 1'b0, 7});
        collect("round_33", 0);
    endtask

    task automatic test_backpressure();
        send(8'h38, 8'h38, '{8'h42, 1'b0, 1'b0, 7});
        collect("backpressure", 5);
    endtask

    task automatic test_reset_mid();
        int seen;
        send(8'h38, 8'h38, '{8'h42, 1'b0, 1'b0, 7});
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_discard: out_valid seen %0d cycles required 0", seen);
        end
        send(8'h38, 8'h38, '{8'h42, 1'b0, 1'b0, 7});
        collect("after_reset", 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            send(a, b, model(a, b));
            collect("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
